ppu_vram_port: RTL and testbench

- CPU-facing PPUADDR/PPUDATA ($2006/$2007) engine and rendering-fetch arbiter for the PPU memory wrapper.
- Owns the 14-bit VRAM address register, the two-write address latch, the delayed-read buffer, and 1/32 auto-increment.
- Merges CPU accesses with the renderer's pattern/nametable fetches onto the single addr/data/rw/q port of the PPU memory wrapper. That port has 1-cycle read latency.

---
 rtl/ppu_pkg.sv | 22 ++
 rtl/ppu_vram_addr_reg.sv | 59 +++++
 rtl/ppu_vram_port.sv | 150 +++++++++++++++
 tb/tb_ppu_vram_port.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ppu_pkg.sv
// Shared definitions for the PPU VRAM access port.
// Provides the CPU register indices that reach the VRAM port, the VRAM address width,
// the CPU-access FSM state type and the read-return ownership tag type.
package ppu_pkg;
   localparam int         VRAM_AW   = 14;

   localparam logic [2:0] PPUSTATUS = 3'd2;
   localparam logic [2:0] PPUADDR   = 3'd6;
   localparam logic [2:0] PPUDATA   = 3'd7;

   typedef enum logic [1:0] {
      IDLE,
      PEND,
      ISSUE
   } vram_state_t;

   typedef enum logic [1:0] {
      TAG_NONE,
      TAG_FETCH,
      TAG_CPU
   } ret_tag_t;
endpackage

// File: rtl/ppu_vram_addr_reg.sv
// VRAM address register (v), its high-byte staging register (t_hi) and the
// shared write latch (w).
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   status_rd   $2002 read this cycle: clears w
//   addr_wr     $2006 write this cycle; wdata carries the byte
//   inc_en      CPU access issued this cycle: step v
//   inc32       selects INC_LARGE instead of INC_SMALL
//   v           current VRAM address
module ppu_vram_addr_reg
   import ppu_pkg::*;
#(
   parameter int INC_SMALL = 1,
   parameter int INC_LARGE = 32,
   parameter int ADDR_W    = VRAM_AW
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              status_rd,
   input  logic              addr_wr,
   input  logic [7:0]        wdata,
   input  logic              inc_en,
   input  logic              inc32,
   output logic [ADDR_W-1:0] v
);

   localparam logic [ADDR_W-1:0] STEP_SMALL = ADDR_W'(INC_SMALL);
   localparam logic [ADDR_W-1:0] STEP_LARGE = ADDR_W'(INC_LARGE);

   logic [ADDR_W-9:0] t_hi;
   logic              w;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v    <= '0;
         t_hi <= '0;
         w    <= 1'b0;
      end else begin
         if (status_rd) begin
            w <= 1'b0;
         end else if (addr_wr) begin
            if (!w) begin
               t_hi <= wdata[ADDR_W-9:0];
               w    <= 1'b1;
            end else begin
               w    <= 1'b0;
            end
         end
         // A completing $2006 write overrides the post-access increment;
         // the sum wraps naturally at ADDR_W bits.
         if (addr_wr && w && !status_rd) begin
            v <= {t_hi, wdata};
         end else if (inc_en) begin
            v <= v + (inc32 ? STEP_LARGE : STEP_SMALL);
         end
      end
   end

endmodule

// File: rtl/ppu_vram_port.sv
// CPU $2006/$2007 engine and renderer-fetch arbiter in front of the PPU memory wrapper.
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   cpu_sel/cpu_reg/cpu_rw/
//   cpu_wdata                     one-cycle CPU register access strobe and payload
//   cpu_rdata                     $2007 read result (delayed-read buffer contents)
//   inc32                         $2007 auto-increment select
//   cpu_busy                      a $2007 access is waiting for or using the bus
//   overrun                       sticky: a $2007 access arrived while busy
//   fetch_req/fetch_addr          renderer read request, strict bus priority
//   fetch_valid/fetch_data        renderer read return, one cycle after the request
//   mem_addr/mem_data/mem_rw/mem_q memory wrapper port, 1-cycle read latency
module ppu_vram_port
   import ppu_pkg::*;
#(
   parameter int INC_SMALL = 1,
   parameter int INC_LARGE = 32,
   parameter int ADDR_W    = VRAM_AW
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cpu_sel,
   input  logic [2:0]        cpu_reg,
   input  logic              cpu_rw,
   input  logic [7:0]        cpu_wdata,
   output logic [7:0]        cpu_rdata,
   input  logic              inc32,
   output logic              cpu_busy,
   output logic              overrun,
   input  logic              fetch_req,
   input  logic [ADDR_W-1:0] fetch_addr,
   output logic              fetch_valid,
   output logic [7:0]        fetch_data,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_data,
   output logic              mem_rw,
   input  logic [7:0]        mem_q
);

   vram_state_t       state, state_nxt, phase;
   ret_tag_t          tag, tag_nxt;
   logic [ADDR_W-1:0] v;
   logic [ADDR_W-1:0] req_addr;
   logic [7:0]        req_wdata;
   logic              req_rw;
   logic [7:0]        rd_buf;
   logic              acc_status, acc_addr_wr, acc_data;
   logic              post, drop, issue;

   assign acc_status  = cpu_sel && (cpu_reg == PPUSTATUS) && !cpu_rw;
   assign acc_addr_wr = cpu_sel && (cpu_reg == PPUADDR) && cpu_rw;
   assign acc_data    = cpu_sel && (cpu_reg == PPUDATA);

   assign cpu_busy = (state != IDLE);
   assign post     = acc_data && !cpu_busy;
   assign drop     = acc_data && cpu_busy;

   assign fetch_valid = (tag == TAG_FETCH);
   assign fetch_data  = mem_q;

   ppu_vram_addr_reg #(
      .INC_SMALL (INC_SMALL),
      .INC_LARGE (INC_LARGE),
      .ADDR_W    (ADDR_W)
   ) u_addr_reg (
      .clk       (clk),
      .rst_n     (rst_n),
      .status_rd (acc_status),
      .addr_wr   (acc_addr_wr),
      .wdata     (cpu_wdata),
      .inc_en    (issue),
      .inc32     (inc32),
      .v         (v)
   );

   // A pending request becomes the ISSUE phase in the same cycle the renderer
   // leaves the bus free, so the earliest issue is the cycle after the post.
   always_comb begin
      state_nxt = state;
      phase     = state;
      tag_nxt   = TAG_NONE;
      issue     = 1'b0;
      mem_addr  = v;
      mem_rw    = 1'b0;
      mem_data  = '0;

      if (state == PEND && !fetch_req) begin
         phase = ISSUE;
      end

      if (fetch_req) begin
         mem_addr = fetch_addr;
         tag_nxt  = TAG_FETCH;
      end

      case (phase)
         IDLE: begin
            if (post) begin
               state_nxt = PEND;
            end
         end
         PEND: begin
            state_nxt = PEND;
         end
         ISSUE: begin
            issue     = 1'b1;
            mem_addr  = req_addr;
            mem_rw    = req_rw;
            mem_data  = req_rw ? req_wdata : 8'h00;
            tag_nxt   = req_rw ? TAG_NONE : TAG_CPU;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         tag       <= TAG_NONE;
         rd_buf    <= '0;
         cpu_rdata <= '0;
         overrun   <= 1'b0;
         req_rw    <= 1'b0;
         req_wdata <= '0;
         req_addr  <= '0;
      end else begin
         state <= state_nxt;
         tag   <= tag_nxt;
         if (tag == TAG_CPU) begin
            rd_buf <= mem_q;
         end
         // $2007 reads return the buffer as it stood before this access.
         if (acc_data && !cpu_rw) begin
            cpu_rdata <= rd_buf;
         end
         if (drop) begin
            overrun <= 1'b1;
         end
         if (post) begin
            req_rw    <= cpu_rw;
            req_wdata <= cpu_wdata;
            req_addr  <= v;
         end
      end
   end

endmodule

// File: tb/tb_ppu_vram_port.sv
module tb_ppu_vram_port;

   logic        clk;
   logic        rst_n;
   logic        cpu_sel;
   logic [2:0]  cpu_reg;
   logic        cpu_rw;
   logic [7:0]  cpu_wdata;
   logic [7:0]  cpu_rdata;
   logic        inc32;
   logic        cpu_busy;
   logic        overrun;
   logic        fetch_req;
   logic [13:0] fetch_addr;
   logic        fetch_valid;
   logic [7:0]  fetch_data;
   logic [13:0] mem_addr;
   logic [7:0]  mem_data;
   logic        mem_rw;
   logic [7:0]  mem_q;

   int n_cmp = 0;
   int n_bad = 0;

   ppu_vram_port dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cpu_sel     (cpu_sel),
      .cpu_reg     (cpu_reg),
      .cpu_rw      (cpu_rw),
      .cpu_wdata   (cpu_wdata),
      .cpu_rdata   (cpu_rdata),
      .inc32       (inc32),
      .cpu_busy    (cpu_busy),
      .overrun     (overrun),
      .fetch_req   (fetch_req),
      .fetch_addr  (fetch_addr),
      .fetch_valid (fetch_valid),
      .fetch_data  (fetch_data),
      .mem_addr    (mem_addr),
      .mem_data    (mem_data),
      .mem_rw      (mem_rw),
      .mem_q       (mem_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] pat(input logic [13:0] a);
      return a[7:0] ^ {a[13:8], 2'b01};
   endfunction

   // Memory wrapper: synchronous write, registered read (1-cycle latency).
   logic [7:0] vram [0:16383];
   bit         vwr  [0:16383];
   always @(posedge clk) begin
      if (mem_rw) begin
         vram[mem_addr] <= mem_data;
         vwr[mem_addr]  <= 1'b1;
      end
      mem_q <= vwr[mem_addr] ? vram[mem_addr] : pat(mem_addr);
   end

   // Reference model state (expected contents of memory and the port's registers).
   logic [7:0]  ref_mem [0:16383];
   int unsigned m_v, m_thi, m_addr;
   bit          m_w, m_pend, m_op, m_ovr, m_fv, m_cret;
   logic [7:0]  m_wd, m_rdbuf, m_rdata, m_fd, m_cval;
   logic        g_i32;

   task automatic check(input string tag, input int unsigned got, input int unsigned exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_v = 0; m_thi = 0; m_addr = 0; m_w = 0; m_pend = 0; m_op = 0; m_ovr = 0;
      m_fv = 0; m_cret = 0; m_wd = 0; m_rdbuf = 0; m_rdata = 0; m_fd = 0; m_cval = 0;
   endtask

   // One clock cycle: apply inputs at the falling edge, check the cycle's outputs,
   // then advance the model across the coming rising edge.
   task automatic cyc(input logic sel, input logic [2:0] rg, input logic rw, input logic [7:0] wd,
                      input logic fr, input logic [13:0] fa, input logic i32);
      bit          issue, acc7, nxt_pend, n_cret;
      logic [7:0]  n_cval;
      int unsigned nv;
      @(negedge clk);
      cpu_sel = sel; cpu_reg = rg; cpu_rw = rw; cpu_wdata = wd;
      fetch_req = fr; fetch_addr = fa; inc32 = i32;
      #1;
      if (fr) begin
         check("bus_addr_fetch", mem_addr, fa);
         check("bus_rw_fetch", mem_rw, 0);
      end else if (m_pend) begin
         check("bus_addr_cpu", mem_addr, m_addr);
         check("bus_rw_cpu", mem_rw, m_op);
         if (m_op) check("bus_data_cpu", mem_data, m_wd);
      end else begin
         check("bus_addr_idle", mem_addr, m_v);
         check("bus_rw_idle", mem_rw, 0);
         check("bus_data_idle", mem_data, 0);
      end
      check("cpu_busy", cpu_busy, m_pend);
      check("overrun", overrun, m_ovr);
      check("cpu_rdata", cpu_rdata, m_rdata);
      check("fetch_valid", fetch_valid, m_fv);
      if (m_fv) check("fetch_data", fetch_data, m_fd);

      issue  = !fr && m_pend;
      nv     = m_v;
      n_cret = 0;
      n_cval = 8'h00;
      if (issue) begin
         if (m_op) ref_mem[m_addr] = m_wd;
         else begin
            n_cret = 1;
            n_cval = ref_mem[m_addr];
         end
         nv = (m_v + (i32 ? 32 : 1)) % 16384;
      end
      acc7 = sel && (rg == 3'd7);
      if (acc7 && !rw) m_rdata = m_rdbuf;
      if (m_cret) m_rdbuf = m_cval;
      nxt_pend = m_pend && !issue;
      if (acc7) begin
         if (m_pend) m_ovr = 1;
         else begin
            nxt_pend = 1; m_op = rw; m_wd = wd; m_addr = m_v;
         end
      end
      if (sel && rg == 3'd2 && !rw) m_w = 0;
      else if (sel && rg == 3'd6 && rw) begin
         if (!m_w) begin
            m_thi = wd & 8'h3F; m_w = 1;
         end else begin
            nv = m_thi * 256 + wd; m_w = 0;
         end
      end
      m_fv   = fr;
      m_fd   = ref_mem[fa];
      m_v    = nv;
      m_pend = nxt_pend;
      m_cret = n_cret;
      m_cval = n_cval;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 14'h0, g_i32);
   endtask

   task automatic set_v(input logic [13:0] a);
      logic [7:0] hi;
      hi = {2'b00, a[13:8]};
      cyc(1'b1, 3'd6, 1'b1, hi, 1'b0, 14'h0, g_i32);
      cyc(1'b1, 3'd6, 1'b1, a[7:0], 1'b0, 14'h0, g_i32);
   endtask

   task automatic wr7(input logic [7:0] d);
      cyc(1'b1, 3'd7, 1'b1, d, 1'b0, 14'h0, g_i32);
   endtask

   task automatic rd7();
      cyc(1'b1, 3'd7, 1'b0, 8'h00, 1'b0, 14'h0, g_i32);
   endtask

   task automatic reset_checks(input string tag);
      check({tag, "_busy"}, cpu_busy, 0);
      check({tag, "_overrun"}, overrun, 0);
      check({tag, "_rdata"}, cpu_rdata, 0);
      check({tag, "_fvalid"}, fetch_valid, 0);
      check({tag, "_mem_rw"}, mem_rw, 0);
      check({tag, "_mem_data"}, mem_data, 0);
      check({tag, "_mem_addr"}, mem_addr, 0);
   endtask

   task automatic apply_reset(input string tag);
      cpu_sel = 0; fetch_req = 0;
      #1 rst_n = 1'b0;
      #1 reset_checks(tag);
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   logic [7:0] exp_rd [0:2];

   initial begin : main
      logic [2:0] rg;
      int         r;
      for (int i = 0; i < 16384; i++) ref_mem[i] = pat(14'(i));
      rst_n = 1'b0; cpu_sel = 0; cpu_reg = 0; cpu_rw = 0; cpu_wdata = 0;
      fetch_req = 0; fetch_addr = 0; inc32 = 0; g_i32 = 0;
      model_reset();
      #3 reset_checks("por");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Address setup then a $2007 write with the bus free.
      set_v(14'h2108);
      wr7(8'h5A);
      idle(1);
      check("t1_issue_rw", mem_rw, 1);
      check("t1_issue_addr", mem_addr, 14'h2108);
      check("t1_issue_data", mem_data, 8'h5A);
      idle(1);
      check("t1_v_after", mem_addr, 14'h2109);

      // Delayed-read buffer.
      set_v(14'h2000); wr7(8'h11); idle(1); wr7(8'h22); idle(1);
      set_v(14'h2000);
      exp_rd[0] = 8'h00; exp_rd[1] = 8'h11; exp_rd[2] = 8'h22;
      for (int k = 0; k < 3; k++) begin
         rd7();
         idle(1);
         check("t2_rdata", cpu_rdata, exp_rd[k]);
         idle(1);
      end
      check("t2_v_end", mem_addr, 14'h2003);

      // Increment wrap at 14 bits.
      g_i32 = 1; set_v(14'h3FF0); wr7(8'hA1); idle(2);
      check("t3_wrap32", mem_addr, 14'h0010);
      set_v(14'h3FE8); wr7(8'hA2); idle(2);
      check("t3_wrap32b", mem_addr, 14'h0008);
      g_i32 = 0; set_v(14'h3FFF); wr7(8'hA3); idle(2);
      check("t3_wrap1", mem_addr, 14'h0000);

      // Fetches hold off a posted write.
      set_v(14'h0555);
      wr7(8'hC3);
      for (int i = 0; i < 5; i++) begin
         cyc(1'b0, 3'd0, 1'b0, 8'h00, 1'b1, 14'h0100 + 14'(i), 1'b0);
         check("t4_busy_fetch", cpu_busy, 1);
         check("t4_rw_fetch", mem_rw, 0);
      end
      idle(1);
      check("t4_issue_rw", mem_rw, 1);
      check("t4_issue_addr", mem_addr, 14'h0555);
      check("t4_busy_issue", cpu_busy, 1);
      idle(1);
      check("t4_busy_done", cpu_busy, 0);

      // $2002 clears the latch; access while busy is dropped.
      cyc(1'b1, 3'd6, 1'b1, 8'h3F, 1'b0, 14'h0, 1'b0);
      cyc(1'b1, 3'd2, 1'b0, 8'h00, 1'b0, 14'h0, 1'b0);
      set_v(14'h1234);
      idle(1);
      check("t5_v_latch", mem_addr, 14'h1234);
      rd7();
      cyc(1'b1, 3'd7, 1'b1, 8'h99, 1'b0, 14'h0, 1'b0);
      idle(1);
      check("t5_overrun", overrun, 1);
      check("t5_v_once", mem_addr, 14'h1235);

      // Reset while a write is pending.
      wr7(8'h77);
      cyc(1'b0, 3'd0, 1'b0, 8'h00, 1'b1, 14'h0005, 1'b0);
      apply_reset("t6");
      for (int i = 0; i < 4; i++) begin
         idle(1);
         check("t6_no_write", mem_rw, 0);
      end

      // Randomized traffic against the model.
      for (int i = 0; i < 600; i++) begin
         r  = $urandom_range(0, 3);
         rg = (r == 0) ? 3'd2 : (r == 1) ? 3'd6 : (r == 2) ? 3'd7 : 3'($urandom_range(0, 7));
         cyc(($urandom_range(0, 2) == 0), rg, 1'($urandom), 8'($urandom),
             ($urandom_range(0, 1) == 1), 14'($urandom), 1'($urandom));
      end
      idle(3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
